// File: rtl/decim_serializer.sv
// Decimated-word output stage: small FIFO feeding an MSB-first three-wire serial link.
// Optional even-parity bit after the LSB when SER_PARITY_EN is defined.
module decim_serializer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int DIV   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         din,
    input  logic                     din_valid,
    input  logic                     clear,
    output logic                     sclk,
    output logic                     sdata,
    output logic                     sframe,
    output logic                     busy,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
`ifdef SER_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int PW = $clog2(2 * DIV) + 1;
    localparam int BW = $clog2(NBITS) + 1;

    localparam logic [PW-1:0] PH_LAST  = PW'(2 * DIV - 1);
    localparam logic [PW-1:0] PH_HALF  = PW'(DIV);
    localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [NBITS-1:0] sreg, sreg_n, load_word;
    logic [PW-1:0]    phase, phase_n;
    logic [BW-1:0]    bit_cnt, bit_n;
    logic             pop, push, drop;

    always_comb begin
`ifdef SER_PARITY_EN
        load_word = {mem[rd_ptr], ^mem[rd_ptr]};
`else
        load_word = mem[rd_ptr];
`endif
    end

    // A new frame starts from IDLE or straight out of the last GAP cycle.
    assign pop  = !clear && (level != '0) &&
                  ((state == IDLE) || ((state == GAP) && (phase == PH_LAST)));
    assign push = din_valid && !clear && ((level != LVL_FULL) || pop);
    assign drop = din_valid && !clear && !push;

    always_comb begin
        state_n = state;
        phase_n = phase;
        bit_n   = bit_cnt;
        sreg_n  = sreg;
        if (clear) begin
            state_n = IDLE;
            phase_n = '0;
            bit_n   = '0;
            sreg_n  = '0;
        end else if (pop) begin
            state_n = SHIFT;
            phase_n = '0;
            bit_n   = '0;
            sreg_n  = load_word;
        end else begin
            case (state)
                SHIFT: begin
                    if (phase == PH_LAST) begin
                        phase_n = '0;
                        if (bit_cnt == BIT_LAST) begin
                            state_n = GAP;
                        end else begin
                            bit_n  = bit_cnt + 1'b1;
                            sreg_n = {sreg[NBITS-2:0], 1'b0};
                        end
                    end else begin
                        phase_n = phase + 1'b1;
                    end
                end
                GAP: begin
                    if (phase == PH_LAST) begin
                        phase_n = '0;
                        state_n = IDLE;
                    end else begin
                        phase_n = phase + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next-state values so they align with the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            phase   <= '0;
            bit_cnt <= '0;
            sreg    <= '0;
            sclk    <= 1'b0;
            sdata   <= 1'b0;
            sframe  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            phase   <= phase_n;
            bit_cnt <= bit_n;
            sreg    <= sreg_n;
            sframe  <= (state_n == SHIFT);
            sclk    <= (state_n == SHIFT) && (phase_n >= PH_HALF);
            sdata   <= (state_n == SHIFT) && sreg_n[NBITS-1];
            busy    <= (state_n != IDLE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (drop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

endmodule

// File: tb/tb_decim_serializer.sv
// Randomized bench for decim_serializer: a queue-based FIFO/link model plus a serial receiver.
module tb_decim_serializer;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int DIV   = 2;
`ifdef SER_PARITY_EN
    localparam int NB = WIDTH + 1;
`else
    localparam int NB = WIDTH;
`endif
    localparam int FRAME  = NB * 2 * DIV;
    localparam int PERIOD = (NB + 1) * 2 * DIV;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [WIDTH-1:0]       din;
    logic                   din_valid, clear;
    logic                   sclk, sdata, sframe, busy, overflow;
    logic [$clog2(DEPTH):0] level;

    decim_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DIV(DIV)) dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .clear(clear),
        .sclk(sclk), .sdata(sdata), .sframe(sframe), .busy(busy),
        .overflow(overflow), .level(level)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Link model: FIFO contents, words sent, time of the next permitted pop.
    logic [WIDTH-1:0] m_q[$];
    logic [WIDTH-1:0] exp_tx[$];
    logic [WIDTH-1:0] rx_q[$];
    int unsigned      starts[$];
    bit               m_active, m_ovf, m_sframe;
    int               m_pop_edge, m_next_pop, edge_n;
    int unsigned      peak;
    logic             last_par;

    task automatic model_reset();
        if (m_sframe) void'(exp_tx.pop_back());
        m_q.delete();
        m_active = 0;
        m_ovf    = 0;
        m_sframe = 0;
    endtask

    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic c);
        bit pop_now;
        din = d; din_valid = v; clear = c;
        @(posedge clk);
        edge_n++;
        if (c) begin
            model_reset();
        end else begin
            pop_now = (m_q.size() > 0) && (!m_active || edge_n >= m_next_pop);
            if (pop_now) begin
                exp_tx.push_back(m_q.pop_front());
                m_active   = 1;
                m_pop_edge = edge_n;
                m_next_pop = edge_n + PERIOD;
            end else if (m_active && edge_n >= m_next_pop) begin
                m_active = 0;
            end
            if (v) begin
                if (m_q.size() < DEPTH) m_q.push_back(d);
                else m_ovf = 1;
            end
        end
        m_sframe = m_active && ((edge_n - m_pop_edge) < FRAME);
        #1;
        din_valid = 1'b0; clear = 1'b0;
        if (level > peak) peak = level;
        check("level", 32'(level), 32'(m_q.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("busy", 32'(busy), 32'(m_active));
        check("sframe", 32'(sframe), 32'(m_sframe));
    endtask

    task automatic drain();
        int unsigned n = 0;
        while ((m_active || m_q.size() != 0) && n < 1000) begin
            step(1'b0, '0, 1'b0);
            n++;
        end
        repeat (3) step(1'b0, '0, 1'b0);
    endtask

    task automatic compare_tx();
        check("tx_count", 32'(rx_q.size()), 32'(exp_tx.size()));
        for (int i = 0; i < rx_q.size() && i < exp_tx.size(); i++)
            check("tx_word", 32'(rx_q[i]), 32'(exp_tx[i]));
        rx_q.delete();
        exp_tx.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_sclk"}, 32'(sclk), 32'd0);
        check({tag, "_sdata"}, 32'(sdata), 32'd0);
        check({tag, "_sframe"}, 32'(sframe), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
        check({tag, "_level"}, 32'(level), 32'd0);
    endtask

    // Receiver: samples sdata on sclk rising while sframe is high.
    logic [WIDTH:0] sh;
    int unsigned    nb, len, negc;
    logic           in_fr = 1'b0, prev_sclk = 1'b0;

    always @(negedge clk) begin
        negc++;
        if (reset) begin
            in_fr = 1'b0;
        end else if (!sframe) begin
            if (in_fr) begin
                in_fr = 1'b0;
                check("frame_len", 32'(len), 32'(FRAME));
                check("frame_bits", 32'(nb), 32'(NB));
`ifdef SER_PARITY_EN
                last_par = sh[0];
                check("parity", 32'(sh[0]), 32'(^sh[WIDTH:1]));
                rx_q.push_back(sh[WIDTH:1]);
`else
                rx_q.push_back(sh[WIDTH-1:0]);
`endif
            end
        end else if (clear) begin
            in_fr = 1'b0;
        end else begin
            if (!in_fr) begin
                in_fr = 1'b1;
                nb = 0;
                len = 0;
                sh = '0;
                starts.push_back(negc);
            end
            len++;
            if (sclk && !prev_sclk) begin
                sh = {sh[WIDTH-1:0], sdata};
                nb++;
            end
        end
        prev_sclk = sclk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] w;
        reset = 1'b1; din = '0; din_valid = 1'b0; clear = 1'b0;
        edge_n = 0; peak = 0; m_active = 0; m_ovf = 0; m_sframe = 0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset = 1'b0;

        // Single word
        step(1'b1, 16'hA5C3, 1'b0);
        drain();
        w = (rx_q.size() != 0) ? rx_q[0] : '0;
        check("single_word", 32'(w), 32'h0000A5C3);
        check("single_idle_busy", 32'(busy), 32'd0);
        check("single_idle_level", 32'(level), 32'd0);
        compare_tx();

        // Back-to-back
        starts.delete(); peak = 0;
        step(1'b1, 16'h0001, 1'b0);
        step(1'b1, 16'h8000, 1'b0);
        step(1'b1, 16'hFFFF, 1'b0);
        drain();
        check("b2b_frames", 32'(starts.size()), 32'd3);
        if (starts.size() >= 3) begin
            check("b2b_period1", 32'(starts[1] - starts[0]), 32'(PERIOD));
            check("b2b_period2", 32'(starts[2] - starts[1]), 32'(PERIOD));
        end
        check("b2b_peak", 32'(peak), 32'd2);
        w = (rx_q.size() >= 2) ? rx_q[1] : '0;
        check("b2b_second", 32'(w), 32'h00008000);
        compare_tx();

        // Overflow
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 16'h0010 + 16'(i), 1'b0);
            if (i == 4) check("ovf_before", 32'(overflow), 32'd0);
        end
        check("ovf_set", 32'(overflow), 32'd1);
        drain();
        check("ovf_frames", 32'(rx_q.size()), 32'd5);
        w = (rx_q.size() >= 5) ? rx_q[4] : '0;
        check("ovf_last_word", 32'(w), 32'h00000014);
        compare_tx();

        // Clear mid-frame with a simultaneous write
        step(1'b1, 16'h1111, 1'b0);
        step(1'b1, 16'h2222, 1'b0);
        step(1'b1, 16'h3333, 1'b0);
        repeat (PERIOD + 20) step(1'b0, '0, 1'b0);
        step(1'b1, 16'hDEAD, 1'b1);
        check("clear_sclk", 32'(sclk), 32'd0);
        check("clear_overflow", 32'(overflow), 32'd0);
        check("clear_level", 32'(level), 32'd0);
        drain();
        check("clear_frames", 32'(rx_q.size()), 32'd1);
        compare_tx();

        // Asynchronous reset mid-frame
        step(1'b1, 16'hBEEF, 1'b0);
        repeat (30) step(1'b0, '0, 1'b0);
        #2 reset = 1'b1;
        #1 check_outputs_zero("async");
        model_reset();
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        reset = 1'b0;
        step(1'b1, 16'h1234, 1'b0);
        drain();
        w = (rx_q.size() != 0) ? rx_q[0] : '0;
        check("after_reset_word", 32'(w), 32'h00001234);
        compare_tx();

`ifdef SER_PARITY_EN
        step(1'b1, 16'h0007, 1'b0);
        drain();
        check("parity_0007", 32'(last_par), 32'd1);
        compare_tx();
        step(1'b1, 16'h0003, 1'b0);
        drain();
        check("parity_0003", 32'(last_par), 32'd0);
        compare_tx();
`endif

        // Randomized traffic, including bursts that overflow
        for (int i = 0; i < 30; i++) begin
            step(1'b1, WIDTH'($urandom), 1'b0);
            repeat ($urandom_range(0, 80)) step(1'b0, '0, 1'b0);
        end
        drain();
        compare_tx();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decim_serializer.md
# decim_serializer

Output stage placed directly downstream of the CIC decimation filter. It captures each decimated word on a one-cycle valid strobe, buffers the words in a small FIFO and shifts them out MSB-first on a three-wire serial link (sclk, sdata, sframe). This lets the full 16-bit result leave the chip over few pins. A sticky overflow flag reports words dropped when the link cannot keep up.

## Interface
- WIDTH, 16: data word width; matches the decimator's OUTPUT_BITS.
- DEPTH, 4: FIFO depth in words; power of two, at least 2.
- DIV, 2: sclk half-period in clk cycles; at least 1.

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- din  in  WIDTH  decimated word (filter Z)
- din_valid  in  1  one-cycle strobe; din is captured on this edge
- clear  in  1  synchronous flush: empties FIFO, aborts frame, clears overflow
- sclk  out  1  serial clock; receiver samples sdata on its rising edge
- sdata  out  1  serial data, MSB first
- sframe  out  1  high for the whole data (+parity) portion of a frame
- busy  out  1  high while a frame or inter-frame gap is in progress
- overflow  out  1  sticky; set when a word is dropped
- level  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH

## Operation
- Reset values: sclk=0, sdata=0, sframe=0, busy=0, overflow=0, level=0; FIFO empty; FSM in IDLE.
- **FIFO write.** A write on din_valid is accepted when level<DEPTH, or when a pop occurs on the same edge.
- **FIFO drop.** Otherwise the word is dropped and overflow is set. Overflow stays set until clear or reset.
- **FSM states.** IDLE, SHIFT, GAP.
- **IDLE.** If level≠0: pop the head into the shift register, reset the bit and phase counters, go to SHIFT. Otherwise stay in IDLE.
- **SHIFT bit timing.** Each bit occupies 2·DIV cycles: sclk=0 for the first DIV cycles, sclk=1 for the next DIV cycles. sdata is stable for the whole bit. sframe=1.
- **SHIFT exit.** After the last bit (bit 0, or the parity bit), go to GAP.
- **GAP.** Lasts 2·DIV cycles with sclk=0, sdata=0, sframe=0. On its last cycle, go directly to SHIFT with a pop if level≠0; otherwise go to IDLE.
- busy = (state≠IDLE).
- **clear.** Priority is clear > din_valid > pop. On the edge where clear is sampled high, the FIFO empties, level becomes 0, overflow becomes 0, the FSM returns to IDLE and all serial outputs are 0. A din_valid on the same edge is discarded.
- **reset mid-frame.** Aborts immediately and asynchronously to the reset values. No partial word is resumed afterwards.
- **Pointers.** Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. level is tracked separately, so full and empty are unambiguous.
- **Rate.** Sustained input must not exceed one word per frame period. At DIV=1 and WIDTH=16, the frame period is 34 cycles. The decimator's 16-cycle Type-2 rate therefore overflows once the FIFO is full; this is expected, and the host uses clear.

## Timing
- **Latency.** din_valid is sampled at edge k into an empty FIFO in IDLE. Then level=1 after edge k. Pop happens at edge k+1. sframe=1 and sdata=din[WIDTH-1] from edge k+1.
- **Frame length.** WIDTH·2·DIV cycles of sframe high, plus 2·DIV more when parity is enabled.
- **Frame period.** Back-to-back frames repeat every (WIDTH+P+1)·2·DIV cycles, where P=1 with parity and P=0 without. There is no extra IDLE cycle between back-to-back frames.
- **level timing.** level updates on the edge after the push or pop. A simultaneous push and pop leaves level unchanged.
- **Output registers.** All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- **SER_PARITY_EN defined.** After the LSB, one additional bit is sent: the even-parity bit, XOR of all WIDTH data bits. sframe stays high through this bit.
- **SER_PARITY_EN undefined.** Frames contain exactly WIDTH bits and no parity logic is built.

## Test plan
- **Single word.** Reset, DIV=2; din=16'hA5C3 with one din_valid pulse.
  - sframe rises one edge after capture and stays high 64 cycles.
  - Bits sampled on sclk rising edges read A5C3, MSB first.
  - A 4-cycle gap follows, then busy=0 and level=0.
- **Back-to-back.** Push 16'h0001, 16'h8000 and 16'hFFFF on consecutive cycles.
  - Three frames in order, each starting 68 cycles after the previous one.
  - level peaks at 2.
- **Overflow.** DEPTH=4; push 6 words in 6 consecutive cycles (0x0010..0x0015).
  - Word 0x0010 is popped; 0x0011..0x0014 are buffered; 0x0015 is dropped.
  - overflow=1 from the edge after the sixth push.
  - Exactly 5 frames are output.
- **Clear.** Assert clear mid-frame with din_valid high on the same edge.
  - Next cycle: sframe=0, sclk=0, level=0, overflow=0, busy=0.
  - The word presented with clear never appears on the link.
- **Async reset.** Assert reset between clock edges mid-frame.
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release, push 16'h1234; it transmits correctly.
- **Parity (SER_PARITY_EN).** din=16'h0007: the 17th bit is 1. din=16'h0003: the 17th bit is 0.
  - sframe is high for 68 cycles when DIV=2.
